data_mem_responder: RTL and testbench

- Responder end of the core's load/store data port. Replaces the zero-wait data memory with a word-addressed RAM behind a valid/ready request/response handshake and a configurable access latency.
- Sits between the pipeline's memory-access stage and local storage.
- One request is outstanding at a time. Each request produces exactly one response carrying read data or an error flag.

---
 rtl/data_mem_responder.sv | 169 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed RAM behind a valid/ready request/response
// handshake. It holds one request at a time and answers it after a fixed,
// parameterised access latency with either read data or an error flag.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // WAIT counts down to zero and the access happens on the edge where it is
    // zero, so LATENCY-2 here makes the response show up LATENCY edges after
    // acceptance.
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          do_access;
    logic [31:0]   acc_addr;
    logic          acc_we;
    logic [3:0]    acc_wstrb;
    logic [31:0]   acc_wdata;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0]   old_word;
    logic [31:0]   wr_word;
    logic          mem_we;

    // Pick the operands of the access: the live request when LATENCY is 1
    // (the access happens on the acceptance edge), the latched copy otherwise.
    always_comb begin
        do_access = 1'b0;
        acc_addr  = addr_q;
        acc_we    = we_q;
        acc_wstrb = wstrb_q;
        acc_wdata = wdata_q;
        if (LATENCY == 1) begin
            acc_addr  = req_addr;
            acc_we    = req_we;
            acc_wstrb = req_wstrb;
            acc_wdata = req_wdata;
            do_access = (state_q == IDLE) && req_valid;
        end else begin
            do_access = (state_q == WAIT) && (cnt_q == 4'd0);
        end
    end

    // Decode the access: misaligned or past-the-end addresses are errors, and
    // stores merge the enabled bytes into the existing word.
    always_comb begin
        acc_err  = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH_WORDS));
        acc_idx  = acc_addr[AW+1:2];
        old_word = mem[acc_idx];
        wr_word  = old_word;
        for (int i = 0; i < 4; i++) begin
            if (acc_wstrb[i]) begin
                wr_word[8*i +: 8] = acc_wdata[8*i +: 8];
            end
        end
        mem_we = do_access && acc_we && !acc_err;
    end

    // Next-state logic for the IDLE/WAIT/RESP handshake sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wstrb_d = req_wstrb;
                    wdata_d = req_wdata;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (do_access) begin
            rdata_d = (acc_we || acc_err) ? 32'h0 : old_word;
            err_d   = acc_err;
        end
    end

    // Control and response registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            wstrb_q <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array: written only on the access edge and never cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= wr_word;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: three instances (LATENCY 2, 1, 4) driven
// through a request/response scoreboard, a vector table and corner sequences.
module tb_data_mem_responder;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic        req_valid [3];
    logic        req_ready [3];
    logic [31:0] req_addr  [3];
    logic        req_we    [3];
    logic [3:0]  req_wstrb [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int   cyc = 0;
    int   acceptCyc = 0;
    int   numChecks = 0;
    int   numFails = 0;
    exp_t sb[$];
    vec_t vecs[$];

    // Free-running clock and edge counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_we(req_we[0]), .req_wstrb(req_wstrb[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .req_we(req_we[1]), .req_wstrb(req_wstrb[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut_l4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_addr(req_addr[2]),
        .req_we(req_we[2]), .req_wstrb(req_wstrb[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        numChecks++;
        numFails++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Present a request, wait (bounded) for acceptance and queue its expected response.
    task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                                 input logic [3:0] wstrb, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err,
                                 input int lat);
        bit ok;
        exp_t e;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wstrb[d] = wstrb;
        req_wdata[d] = wdata;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_ready[d]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            reportTimeout("accept");
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acceptCyc    = cyc;
        req_valid[d] = 1'b0;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = lat;
        sb.push_back(e);
    endtask

    // Wait (bounded) for rsp_valid and compare against the scoreboard head.
    task automatic collectResponse(input int d, input string name);
        bit   ok;
        exp_t e;
        int   lat;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rsp_valid[d]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            reportTimeout({name, " response"});
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            reportTimeout({name, " scoreboard empty"});
            return;
        end
        e   = sb.pop_front();
        lat = cyc + 1 - acceptCyc;
        checkOutput({name, " rdata"}, rsp_rdata[d], e.rdata);
        checkOutput({name, " err"}, {31'b0, rsp_err[d]}, {31'b0, e.err});
        checkOutput({name, " latency"}, 32'(lat), 32'(e.lat));
    endtask

    // Complete the response handshake and check the responder returned to IDLE.
    task automatic finishHandshake(input int d, input string name);
        @(posedge clk);
        #1;
        checkOutput({name, " rsp_valid drop"}, {31'b0, rsp_valid[d]}, 32'h0);
        checkOutput({name, " req_ready back"}, {31'b0, req_ready[d]}, 32'h1);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            req_valid[d] = 1'b0;
            req_addr[d]  = 32'h0;
            req_we[d]    = 1'b0;
            req_wstrb[d] = 4'h0;
            req_wdata[d] = 32'h0;
            rsp_ready[d] = 1'b1;
        end
        rst = 1'b0;

        vecs.push_back('{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0010, 4'h5, 32'h00AA0011, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_0010, 4'h0, 32'h0,        32'hDEAABE11, 1'b0});
        vecs.push_back('{1'b0, 32'h0000_0013, 4'h0, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0000_0400, 4'h0, 32'h0,        32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h0000_0000, 4'hF, 32'h11223344, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h0000_0400, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0000_0000, 4'h0, 32'h0,        32'h11223344, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_03FC, 4'hF, 32'hA5A5A5A5, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0000_03FC, 4'h0, 32'h0,        32'hA5A5A5A5, 1'b0});
        vecs.push_back('{1'b1, 32'h0000_0020, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h0000_0000, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h0000_0002, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0000_0000, 4'h0, 32'h0,        32'h11223344, 1'b0});
        vecs.push_back('{1'b0, 32'h8000_0000, 4'h0, 32'h0,        32'h0,        1'b1});

        #1;
        checkOutput("reset req_ready", {31'b0, req_ready[0]}, 32'h1);
        checkOutput("reset rsp_valid", {31'b0, rsp_valid[0]}, 32'h0);
        checkOutput("reset rsp_rdata", rsp_rdata[0], 32'h0);
        checkOutput("reset rsp_err", {31'b0, rsp_err[0]}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(0, vecs[i].we, vecs[i].addr, vecs[i].wstrb, vecs[i].wdata,
                          vecs[i].exp_rdata, vecs[i].exp_err, 2);
            checkOutput($sformatf("vec%0d req_ready busy", i), {31'b0, req_ready[0]}, 32'h0);
            collectResponse(0, $sformatf("vec%0d", i));
            finishHandshake(0, $sformatf("vec%0d", i));
        end

        // Backpressure: response held for 5 cycles, competing request ignored.
        rsp_ready[0] = 1'b0;
        applyStimulus(0, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEAABE11, 1'b0, 2);
        collectResponse(0, "bp");
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("bp c%0d rsp_valid", i), {31'b0, rsp_valid[0]}, 32'h1);
            checkOutput($sformatf("bp c%0d rsp_rdata", i), rsp_rdata[0], 32'hDEAABE11);
            checkOutput($sformatf("bp c%0d req_ready", i), {31'b0, req_ready[0]}, 32'h0);
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        finishHandshake(0, "bp");
        @(posedge clk);
        #1;
        acceptCyc    = cyc;
        req_valid[0] = 1'b0;
        sb.push_back('{32'h11223344, 1'b0, 2});
        checkOutput("bp second accepted", {31'b0, req_ready[0]}, 32'h0);
        collectResponse(0, "bp second");
        finishHandshake(0, "bp second");

        // Latency variants.
        applyStimulus(1, 1'b1, 32'h8, 4'hF, 32'h55AA55AA, 32'h0, 1'b0, 1);
        collectResponse(1, "l1 store");
        finishHandshake(1, "l1 store");
        applyStimulus(1, 1'b0, 32'h8, 4'h0, 32'h0, 32'h55AA55AA, 1'b0, 1);
        collectResponse(1, "l1 load");
        finishHandshake(1, "l1 load");
        applyStimulus(2, 1'b1, 32'h8, 4'hF, 32'h0BADCAFE, 32'h0, 1'b0, 4);
        collectResponse(2, "l4 store");
        finishHandshake(2, "l4 store");
        applyStimulus(2, 1'b0, 32'h8, 4'h0, 32'h0, 32'h0BADCAFE, 1'b0, 4);
        collectResponse(2, "l4 load");
        finishHandshake(2, "l4 load");

        // Reset during WAIT abandons the store and issues no response.
        applyStimulus(0, 1'b1, 32'h20, 4'hF, 32'h12345678, 32'h0, 1'b0, 2);
        rst = 1'b0;
        #1;
        checkOutput("mid-reset req_ready", {31'b0, req_ready[0]}, 32'h1);
        checkOutput("mid-reset rsp_valid", {31'b0, rsp_valid[0]}, 32'h0);
        checkOutput("mid-reset rsp_rdata", rsp_rdata[0], 32'h0);
        checkOutput("mid-reset rsp_err", {31'b0, rsp_err[0]}, 32'h0);
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("in-reset c%0d rsp_valid", i), {31'b0, rsp_valid[0]}, 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);
        checkOutput("post-reset rsp_valid", {31'b0, rsp_valid[0]}, 32'h0);
        applyStimulus(0, 1'b0, 32'h20, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0, 2);
        collectResponse(0, "post-reset load");
        finishHandshake(0, "post-reset load");

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
